fetch_stage: RTL and testbench

Instruction-fetch stage that consumes the EX-stage branch unit's redirect outputs (`PCSrc`, `PC_Branch`, `IF_ID_Flush`, `branch_index`). It owns the program counter and drives a request/ready handshake to instruction memory. It loads the IF/ID pipeline register and honours stall from the hazard unit and flush/redirect from the branch unit. An optional branch target buffer supplies next-PC predictions.

---
 rtl/riscv_pkg.sv | 10 +
 rtl/fetch_btb.sv | 43 ++++
 rtl/fetch_stage.sv | 144 ++++++++++++++
 tb/tb_fetch_stage.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions used by the fetch stage and its BTB.
package riscv_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer: combinational lookup, one write port.
// Lookup returns the old contents when a write hits the same entry this cycle.
module fetch_btb #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lookup_pc,
    output logic        hit,
    output logic [31:0] target,
    input  logic        wr_en,
    input  logic [31:0] wr_pc,
    input  logic [31:0] wr_target
);
    localparam int IW = $clog2(ENTRIES);
    localparam int TW = 30 - IW;

    logic [ENTRIES-1:0] valid;
    logic [TW-1:0]      tags    [ENTRIES];
    logic [31:0]        targets [ENTRIES];
    logic [IW-1:0]      rd_idx, wr_idx;
    logic               unused_bits;

    assign rd_idx      = lookup_pc[IW+1:2];
    assign wr_idx      = wr_pc[IW+1:2];
    assign unused_bits = ^{lookup_pc[1:0], wr_pc[1:0]};

    assign hit    = valid[rd_idx] && (tags[rd_idx] == lookup_pc[31:IW+2]);
    assign target = targets[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        valid <= '0;
        else if (wr_en) valid[wr_idx] <= 1'b1;
    end

    // Tag/target storage needs no reset; the valid bits gate it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx]    <= wr_pc[31:IW+2];
            targets[wr_idx] <= wr_target;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the imem request/ready handshake and the IF/ID register.
// Define FETCH_BTB_EN to add a branch target buffer for next-PC prediction.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrc,
    input  logic [31:0] PC_Branch,
    input  logic [31:0] branch_index,
    input  logic        IF_ID_Flush,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_Instr,
    output logic        IF_ID_Valid,
    output logic        IF_ID_Pred
);
    fetch_state_t state;
    logic [31:0]  pc, buffer, pending, next_pc, btb_target, new_data;
    logic         req, btb_hit, new_instr;

`ifdef FETCH_BTB_EN
    fetch_btb #(.ENTRIES(BTB_ENTRIES)) u_btb (
        .clk       (clk),
        .rst       (rst),
        .lookup_pc (pc),
        .hit       (btb_hit),
        .target    (btb_target),
        .wr_en     (PCSrc),
        .wr_pc     (branch_index),
        .wr_target (PC_Branch)
    );
`else
    logic unused_btb;
    assign btb_hit    = 1'b0;
    assign btb_target = '0;
    assign unused_btb = ^branch_index;
`endif

    assign next_pc   = btb_hit ? btb_target : pc + 32'd4;
    assign imem_req  = req;
    assign imem_addr = {pc[31:2], 2'b00};

    // A word reaches IF/ID either straight from memory or from the HOLD buffer.
    always_comb begin
        new_instr = 1'b0;
        new_data  = imem_rdata;
        if (!PCSrc && !stall) begin
            if (state == FETCH && req && imem_ready) begin
                new_instr = 1'b1;
            end else if (state == HOLD) begin
                new_instr = 1'b1;
                new_data  = buffer;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            req     <= 1'b0;
            buffer  <= '0;
            pending <= '0;
        end else begin
            case (state)
                FETCH: begin
                    // req is low only in the first cycle out of reset
                    if (!req) begin
                        req <= 1'b1;
                        if (PCSrc) pc <= PC_Branch;
                    end else if (PCSrc) begin
                        if (imem_ready) begin
                            pc <= PC_Branch;
                        end else begin
                            pending <= PC_Branch;
                            state   <= DROP;
                        end
                    end else if (imem_ready) begin
                        if (stall) begin
                            buffer <= imem_rdata;
                            req    <= 1'b0;
                            state  <= HOLD;
                        end else begin
                            pc <= next_pc;
                        end
                    end
                end
                HOLD: begin
                    if (PCSrc) begin
                        pc     <= PC_Branch;
                        buffer <= '0;
                        req    <= 1'b1;
                        state  <= FETCH;
                    end else if (!stall) begin
                        pc    <= next_pc;
                        req   <= 1'b1;
                        state <= FETCH;
                    end
                end
                DROP: begin
                    if (imem_ready) begin
                        pc    <= PCSrc ? PC_Branch : pending;
                        state <= FETCH;
                    end else if (PCSrc) begin
                        pending <= PC_Branch;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            IF_ID_PC    <= '0;
            IF_ID_Instr <= NOP_INSTR;
            IF_ID_Valid <= 1'b0;
            IF_ID_Pred  <= 1'b0;
        end else if (IF_ID_Flush || PCSrc) begin
            IF_ID_Instr <= NOP_INSTR;
            IF_ID_Valid <= 1'b0;
            IF_ID_Pred  <= 1'b0;
        end else if (stall) begin
            IF_ID_Valid <= IF_ID_Valid;
        end else if (new_instr) begin
            IF_ID_PC    <= pc;
            IF_ID_Instr <= new_data;
            IF_ID_Valid <= 1'b1;
            IF_ID_Pred  <= btb_hit;
        end else begin
            IF_ID_Instr <= NOP_INSTR;
            IF_ID_Valid <= 1'b0;
            IF_ID_Pred  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns addr ^ 0x5555_0000 unless a fixed word is forced.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        PCSrc, IF_ID_Flush, stall, imem_ready;
    logic [31:0] PC_Branch, branch_index, imem_rdata;
    logic        imem_req, IF_ID_Valid, IF_ID_Pred;
    logic [31:0] imem_addr, IF_ID_PC, IF_ID_Instr;
    logic        use_fixed;
    logic [31:0] fixed_data;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata = use_fixed ? fixed_data : (imem_addr ^ 32'h5555_0000);

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .PCSrc        (PCSrc),
        .PC_Branch    (PC_Branch),
        .branch_index (branch_index),
        .IF_ID_Flush  (IF_ID_Flush),
        .stall        (stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .IF_ID_PC     (IF_ID_PC),
        .IF_ID_Instr  (IF_ID_Instr),
        .IF_ID_Valid  (IF_ID_Valid),
        .IF_ID_Pred   (IF_ID_Pred)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; PCSrc = 1'b0; IF_ID_Flush = 1'b0; stall = 1'b0; imem_ready = 1'b1;
        PC_Branch = '0; branch_index = '0; use_fixed = 1'b0; fixed_data = '0;
        step(); step();
        chk("rst_req",   {31'd0, imem_req},    32'd0);
        chk("rst_instr", IF_ID_Instr,          32'h13);
        chk("rst_valid", {31'd0, IF_ID_Valid}, 32'd0);
        chk("rst_pc",    IF_ID_PC,             32'd0);
        chk("rst_pred",  {31'd0, IF_ID_Pred},  32'd0);
        rst = 1'b0;

        // streaming with zero-wait memory
        step();
        chk("s0_req",   {31'd0, imem_req},    32'd1);
        chk("s0_addr",  imem_addr,            32'h0);
        chk("s0_valid", {31'd0, IF_ID_Valid}, 32'd0);
        step();
        chk("s1_addr",  imem_addr,            32'h4);
        chk("s1_idpc",  IF_ID_PC,             32'h0);
        chk("s1_instr", IF_ID_Instr,          32'h5555_0000);
        chk("s1_valid", {31'd0, IF_ID_Valid}, 32'd1);
        step();
        chk("s2_addr",  imem_addr,            32'h8);
        chk("s2_idpc",  IF_ID_PC,             32'h4);

        // redirect while memory is busy -> DROP
        imem_ready = 1'b0; PCSrc = 1'b1; PC_Branch = 32'h100;
        step();
        PCSrc = 1'b0;
        chk("drop_req",   {31'd0, imem_req},    32'd1);
        chk("drop_addr",  imem_addr,            32'h8);
        chk("drop_valid", {31'd0, IF_ID_Valid}, 32'd0);
        step();
        chk("drop_hold_addr", imem_addr, 32'h8);
        imem_ready = 1'b1;
        step();
        chk("drop_redir_addr", imem_addr,            32'h100);
        chk("drop_bubble",     {31'd0, IF_ID_Valid}, 32'd0);
        step();
        chk("redir_idpc",  IF_ID_PC,    32'h100);
        chk("redir_instr", IF_ID_Instr, 32'h5555_0100);
        chk("redir_addr",  imem_addr,   32'h104);

        // stalled completion -> HOLD buffer
        stall = 1'b1; use_fixed = 1'b1; fixed_data = 32'hDEAD_BEEF;
        step();
        imem_ready = 1'b0; use_fixed = 1'b0;
        chk("hold_req",  {31'd0, imem_req}, 32'd0);
        chk("hold_idpc", IF_ID_PC,          32'h100);
        step();
        chk("hold_req2", {31'd0, imem_req}, 32'd0);
        stall = 1'b0;
        step();
        chk("rel_instr", IF_ID_Instr,          32'hDEAD_BEEF);
        chk("rel_idpc",  IF_ID_PC,             32'h104);
        chk("rel_valid", {31'd0, IF_ID_Valid}, 32'd1);
        chk("rel_addr",  imem_addr,            32'h108);
        chk("rel_req",   {31'd0, imem_req},    32'd1);
        step();
        chk("wait_bubble", {31'd0, IF_ID_Valid}, 32'd0);
        chk("wait_addr",   imem_addr,            32'h108);

        // flush wins over stall
        imem_ready = 1'b1;
        step();
        chk("pre_flush_valid", {31'd0, IF_ID_Valid}, 32'd1);
        stall = 1'b1; IF_ID_Flush = 1'b1; imem_ready = 1'b0;
        step();
        chk("flush_instr", IF_ID_Instr,          32'h13);
        chk("flush_valid", {31'd0, IF_ID_Valid}, 32'd0);
        chk("flush_addr",  imem_addr,            32'h10C);
        stall = 1'b0; IF_ID_Flush = 1'b0;

        // latest redirect wins in DROP
        PCSrc = 1'b1; PC_Branch = 32'h300;
        step();
        PC_Branch = 32'h400;
        step();
        PCSrc = 1'b0; imem_ready = 1'b1;
        step();
        chk("latest_addr", imem_addr, 32'h400);

        // reset in the middle of DROP acts immediately
        imem_ready = 1'b0; PCSrc = 1'b1; PC_Branch = 32'h500;
        step();
        PCSrc = 1'b0;
        chk("drop2_addr", imem_addr, 32'h400);
        rst = 1'b1;
        #2;
        chk("arst_req",   {31'd0, imem_req}, 32'd0);
        chk("arst_idpc",  IF_ID_PC,          32'h0);
        chk("arst_instr", IF_ID_Instr,       32'h13);
        step();
        rst = 1'b0; imem_ready = 1'b1;
        step();
        chk("restart_addr0", imem_addr, 32'h0);
        step();
        chk("restart_addr4", imem_addr, 32'h4);

        // PC wraps from the top of the address space
        PCSrc = 1'b1; PC_Branch = 32'hFFFF_FFFC;
        step();
        PCSrc = 1'b0;
        chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_addr",  imem_addr,   32'h0);
        chk("wrap_idpc",  IF_ID_PC,    32'hFFFF_FFFC);
        chk("wrap_instr", IF_ID_Instr, 32'hAAAA_FFFC);
`ifndef FETCH_BTB_EN
        chk("nobtb_pred", {31'd0, IF_ID_Pred}, 32'd0);
`else
        // train 0x40 -> 0x200, then jump to 0x40 and expect a predicted fetch
        PCSrc = 1'b1; branch_index = 32'h40; PC_Branch = 32'h200;
        step();
        branch_index = 32'h84; PC_Branch = 32'h40;
        step();
        PCSrc = 1'b0;
        chk("btb_addr40", imem_addr, 32'h40);
        step();
        chk("btb_target", imem_addr,           32'h200);
        chk("btb_idpc",   IF_ID_PC,            32'h40);
        chk("btb_pred",   {31'd0, IF_ID_Pred}, 32'd1);
        step();
        chk("btb_nopred", {31'd0, IF_ID_Pred}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
